piso_packet_rx: RTL

//  FPGA/MCP-side receiver for one LArPix v3 PISO UART lane; consumes the chip's piso output.

---
 rtl/piso_packet_rx_if.sv | 12 +
 rtl/piso_packet_rx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/piso_packet_rx_if.sv
// piso_packet_rx_if: packet valid/ready bus between the PISO receiver (master) and its consumer (slave).
interface piso_packet_rx_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] pkt_data;
    logic             pkt_parity_ok;
    logic             pkt_valid;
    logic             pkt_ready;

    modport master (output pkt_data, pkt_parity_ok, pkt_valid, input pkt_ready);
    modport slave  (input pkt_data, pkt_parity_ok, pkt_valid, output pkt_ready);
endinterface

// File: rtl/piso_packet_rx.sv
// piso_packet_rx: LArPix PISO UART lane receiver with odd-parity check, packet FIFO and valid/ready output.
// Define PISO_RX_STATS_EN to build the saturating statistics counters; otherwise stats_* read 0.
module piso_packet_rx #(
    parameter int WIDTH        = 64,
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int FIFO_BITS    = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             piso,
    piso_packet_rx_if.master pkt,
    output logic             framing_err,
    output logic             overflow,
    output logic             rx_busy,
    input  logic             stats_clr,
    output logic [15:0]      stats_rx,
    output logic [15:0]      stats_par,
    output logic [15:0]      stats_frm,
    output logic [15:0]      stats_ovf
);
    localparam int BW   = $clog2(CLKS_PER_BIT);
    localparam int CW   = $clog2(WIDTH);
    localparam int HALF = CLKS_PER_BIT / 2;

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

    state_t st, st_n;
    logic [1:0] sync;
    logic line;
    logic [BW-1:0] baud, baud_n;
    logic [CW-1:0] bitc, bitc_n;
    logic tick, push, ferr;
    logic [WIDTH-1:0] sh;
    logic [WIDTH:0] mem [FIFO_DEPTH];
    logic [WIDTH:0] head;
    logic [FIFO_BITS:0] wr, rd;
    logic empty, full, pop, wr_en, drop;

    // Synchronizer clears to 0 so WAIT_IDLE must see the real line high before leaving.
    always_ff @(posedge clk) begin
        if (!reset_n)
            sync <= 2'b00;
        else
            sync <= {sync[0], piso};
    end
    assign line = sync[1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st   <= WAIT_IDLE;
            baud <= '0;
            bitc <= '0;
        end else begin
            st   <= st_n;
            baud <= baud_n;
            bitc <= bitc_n;
        end
    end

    always_comb begin
        st_n   = st;
        baud_n = baud + 1'b1;
        bitc_n = bitc;
        push   = 1'b0;
        ferr   = 1'b0;
        tick   = (st == START) ? (baud == BW'(HALF - 1)) : (baud == BW'(CLKS_PER_BIT - 1));
        case (st)
            WAIT_IDLE: begin
                baud_n = '0;
                st_n   = line ? IDLE : WAIT_IDLE;
            end
            IDLE: begin
                baud_n = '0;
                st_n   = line ? IDLE : START;
            end
            START: if (tick) begin
                baud_n = '0;
                st_n   = line ? IDLE : DATA;
            end
            DATA: if (tick) begin
                baud_n = '0;
                bitc_n = (bitc == CW'(WIDTH - 1)) ? '0 : bitc + 1'b1;
                st_n   = (bitc == CW'(WIDTH - 1)) ? STOP : DATA;
            end
            STOP: if (tick) begin
                baud_n = '0;
                push   = line;
                ferr   = !line;
                st_n   = line ? IDLE : WAIT_IDLE;
            end
            default: st_n = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (st == DATA && tick)
            sh <= {line, sh[WIDTH-1:1]};
    end

    assign empty = wr == rd;
    assign full  = (wr[FIFO_BITS] != rd[FIFO_BITS]) && (wr[FIFO_BITS-1:0] == rd[FIFO_BITS-1:0]);
    assign pop   = !empty && pkt.pkt_ready;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    // Parity is stored beside the word so the head read stays a plain RAM lookup.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr[FIFO_BITS-1:0]] <= {^sh, sh};
    end

    assign head              = mem[rd[FIFO_BITS-1:0]];
    assign pkt.pkt_valid     = !empty;
    assign pkt.pkt_data      = empty ? '0 : head[WIDTH-1:0];
    assign pkt.pkt_parity_ok = !empty && head[WIDTH];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr          <= '0;
            rd          <= '0;
            framing_err <= 1'b0;
            overflow    <= 1'b0;
            rx_busy     <= 1'b0;
        end else begin
            if (wr_en)
                wr <= wr + 1'b1;
            if (pop)
                rd <= rd + 1'b1;
            framing_err <= ferr;
            overflow    <= drop;
            rx_busy     <= st_n != IDLE;
        end
    end

`ifdef PISO_RX_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic inc);
        return (inc && c != 16'hFFFF) ? c + 16'd1 : c;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n || stats_clr) begin
            stats_rx  <= '0;
            stats_par <= '0;
            stats_frm <= '0;
            stats_ovf <= '0;
        end else begin
            stats_rx  <= sat_inc(stats_rx, wr_en);
            stats_par <= sat_inc(stats_par, wr_en && !(^sh));
            stats_frm <= sat_inc(stats_frm, ferr);
            stats_ovf <= sat_inc(stats_ovf, drop);
        end
    end
`else
    logic unused_clr;
    assign unused_clr = stats_clr;
    assign stats_rx   = '0;
    assign stats_par  = '0;
    assign stats_frm  = '0;
    assign stats_ovf  = '0;
`endif
endmodule
